// File: rtl/kx_pkg.sv
// Shared definitions for the branch unit: datapath width, branch opcodes
// and controller state encoding.
package kx_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        OP_JMP = 2'b00,
        OP_BT  = 2'b01,
        OP_BF  = 2'b10,
        OP_RSV = 2'b11
    } br_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_e;

endpackage

// File: rtl/branch_unit.sv
// Branch unit: owns the program counter and the compare flag, and resolves
// JMP/BT/BF requests by fetching the inline target word that follows the branch.
module branch_unit
    import kx_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              cmp_in,
    input  logic              cmp_we,
    input  logic              inc,
    input  logic              br_valid,
    input  logic [1:0]        br_op,
    output logic              br_ready,
    output logic              tgt_req,
    input  logic [DATA_W-1:0] tgt_data,
    input  logic              tgt_valid,
    output logic [DATA_W-1:0] pc,
    output logic              cond_flag,
    output logic              done,
    output logic              taken,
    output logic              illegal
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   pc_inc;
    logic                flag_q, flag_d;
    logic                snap_q, snap_d;
    logic                done_q, done_d;
    logic                taken_q, taken_d;
    logic                illegal_q, illegal_d;
    logic                flag_now;

    assign pc_inc = pc_q + DATA_W'(1);

    // A compare written in the accept cycle is visible to that same branch.
    assign flag_now = cmp_we ? cmp_in : flag_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        flag_d    = flag_now;
        snap_d    = snap_q;
        done_d    = 1'b0;
        taken_d   = 1'b0;
        illegal_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (br_valid) begin
                    if (br_op == OP_RSV) begin
                        illegal_d = 1'b1;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                        case (br_op)
                            OP_BT:   snap_d = flag_now;
                            OP_BF:   snap_d = ~flag_now;
                            default: snap_d = 1'b1;
                        endcase
                    end
                end else if (inc) begin
                    pc_d = pc_inc;
                end
            end
            ST_FETCH: begin
                if (tgt_valid) begin
                    pc_d    = snap_q ? tgt_data : pc_inc;
                    done_d  = 1'b1;
                    taken_d = snap_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            flag_q    <= 1'b0;
            snap_q    <= 1'b0;
            done_q    <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            flag_q    <= flag_d;
            snap_q    <= snap_d;
            done_q    <= done_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    assign br_ready  = (state_q == ST_IDLE);
    assign tgt_req   = (state_q == ST_FETCH);
    assign pc        = pc_q;
    assign cond_flag = flag_q;
    assign done      = done_q;
    assign taken     = taken_q;
    assign illegal   = illegal_q;

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 clock  in  1  rising-edge system clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cmp_in  in  1  comparator result from the upstream compare stage.
REQ-005 cmp_we  in  1  latch cmp_in into cond_flag this edge.
REQ-006 inc  in  1  sequential-advance request, PC <= PC+1.
REQ-007 br_valid  in  1  branch request valid.
REQ-008 br_op  in  2  00 JMP, 01 BT (branch if flag), 10 BF (branch if not flag), 11 reserved.
REQ-009 br_ready  out  1  high only in IDLE.
REQ-010 tgt_req  out  1  request for the target word at address pc; high throughout FETCH.
REQ-011 tgt_data  in  16  target address word.
REQ-012 tgt_valid  in  1  tgt_data valid; ignored outside FETCH.
REQ-013 pc  out  16  program counter.
REQ-014 cond_flag  out  1  stored compare result.
REQ-015 done  out  1  one-cycle pulse when a branch completes.
REQ-016 taken  out  1  one-cycle pulse, coincident with done, when the PC was loaded from the target.
REQ-017 illegal  out  1  one-cycle pulse on a br_op=11 request in IDLE.

Function
REQ-018 States SHALL be IDLE and FETCH only.
REQ-019 IDLE, br_valid=1, br_op in {00,01,10}: SHALL accept the request, set PC <= PC+1 (the PC then points at the target word), snapshot the condition, and go to FETCH.
REQ-020 Condition snapshot SHALL be: JMP -> 1; BT -> f; BF -> !f. f is cmp_in if cmp_we=1 in the accept cycle, otherwise cond_flag.
REQ-021 FETCH with tgt_valid=1: SHALL set PC <= tgt_data if the snapshot is 1, otherwise PC <= PC+1 (skip the target word). SHALL return to IDLE, pulse done for one cycle, and pulse taken for one cycle if the branch was taken.
REQ-022 FETCH with tgt_valid=0: SHALL hold the PC and state and keep tgt_req=1; there is no timeout.
REQ-023 Branch latency from the accept edge: minimum 2 edges to the PC update (accept, then tgt_valid in the first FETCH cycle); done is visible in the cycle after the update.
REQ-024 IDLE, br_op=11 with br_valid=1: SHALL not be accepted; PC unchanged; illegal pulses for one cycle.
REQ-025 IDLE, inc=1 with br_valid=0: PC <= PC+1.
REQ-026 inc=1 and br_valid=1 in the same cycle: the branch wins and inc is dropped (no double increment).
REQ-027 inc or br_valid during FETCH: SHALL be ignored.
REQ-028 cmp_we SHALL update cond_flag in any state; a cmp_we during FETCH does not change the captured snapshot.
REQ-029 PC arithmetic SHALL be unsigned modulo 2^16: FFFF+1 = 0000, with no carry output.
REQ-030 done, taken and illegal SHALL be registered outputs, never high together with illegal.

Reset
REQ-031 reset SHALL force, at the next edge: state IDLE; pc=0000; cond_flag=0; snapshot=0; done, taken, illegal, tgt_req all 0; br_ready=1 in the following cycle.
REQ-032 reset during FETCH SHALL abandon the branch with no done pulse; a tgt_valid in the same cycle is ignored.
REQ-033 reset SHALL take priority over all other inputs.

Structure
REQ-034 Shared package kx_pkg SHALL hold: the data-width constant (16), the br_op encodings (JMP, BT, BF, RSV), and the state encoding.
REQ-035 Single module with no sub-module; the PC incrementer and the flag register are inline.

Verification
REQ-036 Reset, then inc pulsed 3 cycles -> pc=0003; done never asserted.
REQ-037 pc=0010, cmp_we=1 with cmp_in=1, then BT with tgt_data=0100 after 2 wait cycles -> tgt_req high 3 cycles, pc=0100, done=1, taken=1.
REQ-038 pc=0010, cond_flag=1, BF, tgt_data=0100 -> pc=0012, done=1, taken=0.
REQ-039 cond_flag=0, BT accepted with cmp_we=1 and cmp_in=1 in the same cycle, plus cmp_we=1 with cmp_in=0 during FETCH -> branch taken; cond_flag ends at 0.
REQ-040 pc=FFFE, JMP with inc also high -> pc=FFFF after accept, then tgt_data=0000 -> pc=0000. Separately, pc=FFFF with inc -> pc=0000.
REQ-041 Two cases: br_op=11 -> illegal pulse, pc unchanged; reset asserted in FETCH -> pc=0000, no done pulse, br_ready=1.
